ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
Iterative multiply/divide unit in the EX stage, directly upstream of the memory-access stage. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers. It drives a stall request to the hazard unit while an operation is in flight. MFHI/MFLO values are read from hi_o/lo_o and forwarded into the EX result path that becomes the memory stage's ALU-out input.

Parameters:
XLEN, 32, operand/register width; only 32 is supported.
OP_W, 3, width of op_i.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset; synchronous, active-high.
start_i  input  1  issue strobe for op_i this cycle.
op_i  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 = no-op.
a_i  input  32  rs value; multiplicand/dividend; source for MTHI/MTLO.
b_i  input  32  rt value; multiplier/divisor.
flush_i  input  1  abort the in-flight op (branch/exception flush).
stall_o  output  1  combinational; high while the unit is busy or accepting a MUL/DIV.
done_o  output  1  one-cycle pulse when HI/LO receive a MUL/DIV result.
hi_o  output  32  HI register.
lo_o  output  32  LO register.

Behaviour:
- Reset: all of the following are synchronous to clk. State=IDLE, hi_o=0, lo_o=0, done_o=0, iteration counter=0. Reset mid-operation aborts the op.
- States: IDLE, MUL, DIV, FIX.
- Acceptance: start_i is sampled only in IDLE with flush_i=0. start_i in any other state is ignored; the hazard unit guarantees this does not happen.
- MTHI/MTLO: written at the accepting edge; no stall; done_o stays 0.
- stall_o = (state!=IDLE) | (start_i & op_i in {0..3} & state==IDLE).
- Accept edge E0, MUL/DIV op:
  - Latch operand magnitudes. Signed ops take the absolute value of each operand.
  - Latch sign flags.
  - Enter MUL (ops 0,1) or DIV (ops 2,3) with count=0.
- MUL: radix-2 shift-add over a 64-bit product, one bit per edge, 32 edges (E1..E32). At E32 the state goes to FIX.
- DIV: radix-2 restoring division, one quotient bit per edge, 32 edges. At E32 the state goes to FIX.
- FIX (edge E33):
  - Apply sign correction.
  - MULT: product negated if sa^sb.
  - DIV: quotient negated if sa^sb; remainder negated if sa.
  - Write hi/lo: product[63:32]/[31:0], or remainder/quotient.
  - Return to IDLE; done_o=1 for the following cycle.
- Latency: stall_o is high for 34 cycles (the accept cycle plus 33 busy cycles); results are visible the cycle after E33.
- Divide by zero (any sign): lo=32'hFFFFFFFF, hi=a_i as issued. Same latency as a normal divide.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- flush_i in any non-IDLE state: next edge goes to IDLE; hi/lo unchanged; no done_o. flush_i together with start_i in IDLE: the start is dropped.
- A new start is accepted in the same cycle that done_o is high.

Optional Feature:
FAST_MUL_EN
- Defined: MULT/MULTU use a single-cycle 64-bit multiplier. hi/lo are written at E0, done_o pulses in the next cycle, and stall_o is never asserted for MULT/MULTU. DIV/DIVU are unchanged.
- Undefined: iterative multiply as specified above.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; stall_o high 34 cycles; one done_o pulse. With FAST_MUL_EN: done the cycle after issue, stall_o never high.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100/0 -> lo=0xFFFFFFFF, hi=0x00000064 after normal latency.
- MTHI 0x12345678, then DIVU 9/2, then flush_i at the 10th busy cycle -> hi stays 0x12345678, no done_o, stall_o low the next cycle; a following MTLO 0xA5A5A5A5 updates lo immediately.
- rst asserted mid-DIV -> next cycle hi=lo=0, stall_o=0, done_o=0; start_i during busy is ignored (result matches the first op only).

Source files
------------

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning the HI/LO registers.
// Optional macro FAST_MUL_EN: single-cycle MULT/MULTU; divides stay iterative.
`timescale 1ns/1ps
module ex_muldiv #(
  parameter int XLEN = 32,
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(1);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(5);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  // Control state (reset)
  logic [1:0]        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;

  // Datapath state (no reset)
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mag_q, mag_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              is_div_q, is_div_d;
  logic              div0_q, div0_d;

  logic              state_idle;
  logic              accept;
  logic              is_signed;
  logic              mul_req;
  logic              div_req;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;

  assign state_idle = (state_q == ST_IDLE);
  assign accept     = state_idle && start_i && !flush_i;
  assign is_signed  = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign mul_req    = start_i && ((op_i == OP_MULT) || (op_i == OP_MULTU));
  assign div_req    = start_i && ((op_i == OP_DIV) || (op_i == OP_DIVU));
  assign a_mag      = (is_signed && a_i[XLEN-1]) ? -a_i : a_i;
  assign b_mag      = (is_signed && b_i[XLEN-1]) ? -b_i : b_i;

`ifdef FAST_MUL_EN
  assign stall_o = !state_idle || div_req;
`else
  assign stall_o = !state_idle || mul_req || div_req;
`endif

  // Shift-add step: acc holds {partial product, remaining multiplier bits}.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring step: acc holds {partial remainder, dividend bits / quotient bits}.
  logic [XLEN+1:0]   div_trial;
  logic [2*XLEN-1:0] div_next;
  assign div_trial = {1'b0, acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {2'b00, mag_q};
  assign div_next  = div_trial[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo_fix  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{XLEN{is_signed & a_i[XLEN-1]}}, a_i};
  assign fast_b    = {{XLEN{is_signed & b_i[XLEN-1]}}, b_i};
  assign fast_prod = fast_a * fast_b;
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mag_d    = mag_q;
    a_raw_d  = a_raw_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sa_d    = is_signed && a_i[XLEN-1];
          sb_d    = is_signed && b_i[XLEN-1];
          a_raw_d = a_i;
          div0_d  = (b_i == '0);
          cnt_d   = '0;
          if (op_i == OP_MTHI) begin
            hi_d = a_i;
          end else if (op_i == OP_MTLO) begin
            lo_d = a_i;
          end else if (mul_req) begin
`ifdef FAST_MUL_EN
            hi_d   = fast_prod[2*XLEN-1:XLEN];
            lo_d   = fast_prod[XLEN-1:0];
            done_d = 1'b1;
`else
            acc_d    = {{XLEN{1'b0}}, b_mag};
            mag_d    = a_mag;
            is_div_d = 1'b0;
            state_d  = ST_MUL;
`endif
          end else if (div_req) begin
            acc_d    = {{XLEN{1'b0}}, a_mag};
            mag_d    = b_mag;
            is_div_d = 1'b1;
            state_d  = ST_DIV;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = (state_q == ST_MUL) ? mul_next : div_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = ST_FIX;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (!flush_i) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod_fix[2*XLEN-1:XLEN];
            lo_d = prod_fix[XLEN-1:0];
          end else if (div0_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // NOTE: operand/accumulator registers are always loaded at accept, so they need no reset.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    mag_q    <= mag_d;
    a_raw_q  <= a_raw_d;
    sa_q     <= sa_d;
    sb_q     <= sb_d;
    is_div_q <= is_div_d;
    div0_q   <= div0_d;
  end

  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written flush/reset/back-to-back sequences.
`timescale 1ns/1ps
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_hi, m_lo;

  ex_muldiv dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: architectural results straight from integer arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sp, q, r;
    longint unsigned up;
    case (op)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        m_hi = sp[63:32]; m_lo = sp[31:0];
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        m_hi = up[63:32]; m_lo = up[31:0];
      end
      3'd2: begin
        if (b == 32'd0) begin
          m_hi = a; m_lo = 32'hFFFFFFFF;
        end else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          m_hi = r[31:0]; m_lo = q[31:0];
        end
      end
      3'd3: begin
        if (b == 32'd0) begin
          m_hi = a; m_lo = 32'hFFFFFFFF;
        end else begin
          m_hi = a % b; m_lo = a / b;
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (done_o) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  // Issue one op, then check stall length, done pulse and HI/LO.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input string name);
    int  stalls;
    int  exp_stall;
    bit  seen;
    bit  is_md;
    is_md     = (op <= 3'd3);
    exp_stall = is_md ? 34 : 0;
`ifdef FAST_MUL_EN
    if (op <= 3'd1) exp_stall = 0;
`endif
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    #1;
    stalls = stall_o ? 1 : 0;
    @(negedge clk);
    start_i = 1'b0; op_i = 3'd6;
    seen = 1'b0;
    if (is_md) begin
      for (int k = 0; k < 60 && !seen; k++) begin
        if (done_o) seen = 1'b1;
        else begin
          if (stall_o) stalls++;
          @(negedge clk);
        end
      end
      check({name, ".done"}, 64'(seen), 64'd1);
    end else begin
      check({name, ".nodone"}, 64'(done_o), 64'd0);
    end
    check({name, ".stall"}, 64'(stalls), 64'(exp_stall));
    check({name, ".hi"}, 64'(hi_o), 64'(eh));
    check({name, ".lo"}, 64'(lo_o), 64'(el));
    if (is_md) begin
      @(negedge clk);
      check({name, ".pulse"}, 64'(done_o), 64'd0);
    end
  endtask

  initial begin
    vec_t        vecs[12];
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bit          seen;
    bit          any_done;

    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{3'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[5]  = '{3'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[6]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{3'd4, 32'h11112222, 32'h00000000, 32'h11112222, 32'h00000000};
    vecs[9]  = '{3'd5, 32'h33334444, 32'h00000000, 32'h11112222, 32'h33334444};
    vecs[10] = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[11] = '{3'd6, 32'h00000001, 32'h00000002, 32'h00000000, 32'hFFFFFFFF};

    rst = 1'b1; start_i = 1'b0; op_i = 3'd6; a_i = '0; b_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset.hi", 64'(hi_o), 64'd0);
    check("reset.lo", 64'(lo_o), 64'd0);
    check("reset.done", 64'(done_o), 64'd0);
    check("reset.stall", 64'(stall_o), 64'd0);

    for (int i = 0; i < 12; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
    m_hi = 32'h00000000;
    m_lo = 32'hFFFFFFFF;

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      model(rop, ra, rb);
      do_op(rop, ra, rb, m_hi, m_lo, $sformatf("rand%0d", i));
    end

    // MTHI, then a DIVU flushed during its 10th busy cycle.
    model(3'd4, 32'h12345678, 32'd0);
    do_op(3'd4, 32'h12345678, 32'd0, m_hi, m_lo, "mthi");
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd3; a_i = 32'd9; b_i = 32'd2;
    @(negedge clk);
    start_i = 1'b0; op_i = 3'd6;
    any_done = done_o;
    repeat (9) begin
      @(negedge clk);
      any_done |= done_o;
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush.stall", 64'(stall_o), 64'd0);
    check("flush.done", 64'(done_o | any_done), 64'd0);
    check("flush.hi", 64'(hi_o), 64'h12345678);
    check("flush.lo", 64'(lo_o), 64'(m_lo));
    repeat (30) begin
      @(negedge clk);
      any_done |= done_o;
    end
    check("flush.late_done", 64'(any_done), 64'd0);
    model(3'd5, 32'hA5A5A5A5, 32'd0);
    do_op(3'd5, 32'hA5A5A5A5, 32'd0, 32'h12345678, 32'hA5A5A5A5, "mtlo");

    // Start together with flush in IDLE is dropped.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd4; a_i = 32'hFFFF0000; flush_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; op_i = 3'd6; flush_i = 1'b0;
    check("flushstart.hi", 64'(hi_o), 64'h12345678);

    // Starts while busy are ignored.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd3; a_i = 32'd1000; b_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0; op_i = 3'd6;
    repeat (5) @(negedge clk);
    start_i = 1'b1; op_i = 3'd4; a_i = 32'hDEADBEEF;
    @(negedge clk);
    op_i = 3'd2; a_i = 32'd5; b_i = 32'd1;
    @(negedge clk);
    start_i = 1'b0; op_i = 3'd6;
    wait_done(seen);
    check("busy.done", 64'(seen), 64'd1);
    check("busy.hi", 64'(hi_o), 64'd6);
    check("busy.lo", 64'(lo_o), 64'd142);

    // Back-to-back: a new divide issued in the done cycle.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd3; a_i = 32'd20; b_i = 32'd3;
    @(negedge clk);
    start_i = 1'b0; op_i = 3'd6;
    wait_done(seen);
    check("b2b.first_done", 64'(seen), 64'd1);
    check("b2b.first_hi", 64'(hi_o), 64'd2);
    check("b2b.first_lo", 64'(lo_o), 64'd6);
    start_i = 1'b1; op_i = 3'd3; a_i = 32'd50; b_i = 32'd7;
    #1;
    check("b2b.accept_stall", 64'(stall_o), 64'd1);
    @(negedge clk);
    start_i = 1'b0; op_i = 3'd6;
    check("b2b.busy", 64'(stall_o), 64'd1);
    wait_done(seen);
    check("b2b.second_done", 64'(seen), 64'd1);
    check("b2b.second_hi", 64'(hi_o), 64'd1);
    check("b2b.second_lo", 64'(lo_o), 64'd7);

    // Reset in the middle of a signed divide.
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd2; a_i = 32'hFFFFFFF9; b_i = 32'd2;
    @(negedge clk);
    start_i = 1'b0; op_i = 3'd6;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.hi", 64'(hi_o), 64'd0);
    check("midrst.lo", 64'(lo_o), 64'd0);
    check("midrst.stall", 64'(stall_o), 64'd0);
    check("midrst.done", 64'(done_o), 64'd0);
    any_done = 1'b0;
    repeat (35) begin
      @(negedge clk);
      any_done |= done_o;
    end
    check("midrst.late_done", 64'(any_done), 64'd0);
    do_op(3'd1, 32'd3, 32'd5, 32'd0, 32'd15, "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
